// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit: FSM states,
// instruction word field positions and the opcode encodings.
package fetch_pkg;

  typedef enum logic [2:0] {IDLE, FETCH, DECODE, ISSUE, HALT} state_t;

  localparam int OPC_MSB  = 7;
  localparam int OPC_LSB  = 5;
  localparam int ADDR_MSB = 4;
  localparam int ADDR_LSB = 0;

  localparam logic [7:0] DEFAULT_HALT_WORD = 8'h0C;

  localparam logic [2:0] OP_ADD  = 3'd0;
  localparam logic [2:0] OP_SUB  = 3'd1;
  localparam logic [2:0] OP_AND  = 3'd2;
  localparam logic [2:0] OP_OR   = 3'd3;
  localparam logic [2:0] OP_NOT  = 3'd4;
  localparam logic [2:0] OP_XOR  = 3'd5;
  localparam logic [2:0] OP_XNOR = 3'd6;
  localparam logic [2:0] OP_NOP  = 3'd7;

  function automatic logic [2:0] opcode_of(input logic [7:0] word);
    return word[OPC_MSB:OPC_LSB];
  endfunction

  function automatic logic [4:0] operand_of(input logic [7:0] word);
    return word[ADDR_MSB:ADDR_LSB];
  endfunction

endpackage

// File: rtl/fetch_pc.sv
// Program counter for the fetch unit: clear, increment and a flag marking
// the last valid program address.
module fetch_pc #(
  parameter int PROG_LEN = 13
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       inc,
  input  logic       clr,
  output logic [4:0] pc,
  output logic       at_last
);

  localparam logic [4:0] LAST_PC = 5'(PROG_LEN - 1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      pc <= '0;
    else if (clr)
      pc <= '0;
    else if (inc)
      pc <= pc + 5'd1;
  end

  assign at_last = (pc == LAST_PC);

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: reads the instruction memory at pc, decodes the word
// and hands each instruction to the execute stage over valid/ready.
module instr_fetch_unit
  import fetch_pkg::*;
#(
  parameter int         PROG_LEN  = 13,
  parameter logic [7:0] HALT_WORD = DEFAULT_HALT_WORD
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       clear,
  output logic [4:0] imem_addr,
  input  logic [7:0] imem_data,
  output logic       exec_valid,
  input  logic       exec_ready,
  output logic [2:0] exec_opcode,
  output logic [4:0] exec_addr,
  output logic       busy,
  output logic       halted,
  output logic [7:0] retired_count
);

  state_t     state;
  logic [7:0] ir;
  logic [4:0] pc;
  logic       at_last;
  logic       accept;
  logic       pc_inc;
  logic       pc_clr;

  // The end-of-program test gates the increment, so pc can never wrap.
  assign accept = (state == ISSUE) && exec_valid && exec_ready;
  assign pc_inc = accept && !at_last;
  assign pc_clr = (state == HALT) && clear;

  fetch_pc #(.PROG_LEN(PROG_LEN)) u_fetch_pc (
    .clk     (clk),
    .rst     (rst),
    .inc     (pc_inc),
    .clr     (pc_clr),
    .pc      (pc),
    .at_last (at_last)
  );

  assign imem_addr = pc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      ir            <= '0;
      exec_valid    <= 1'b0;
      exec_opcode   <= '0;
      exec_addr     <= '0;
      busy          <= 1'b0;
      halted        <= 1'b0;
      retired_count <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state <= FETCH;
            busy  <= 1'b1;
          end
        end
        FETCH: begin
          ir    <= imem_data;
          state <= DECODE;
        end
        DECODE: begin
          if (ir == HALT_WORD) begin
            state  <= HALT;
            busy   <= 1'b0;
            halted <= 1'b1;
          end else begin
            exec_opcode <= opcode_of(ir);
            exec_addr   <= operand_of(ir);
            exec_valid  <= 1'b1;
            state       <= ISSUE;
          end
        end
        ISSUE: begin
          if (exec_valid && exec_ready) begin
            exec_valid <= 1'b0;
            if (retired_count != 8'hFF)
              retired_count <= retired_count + 8'd1;
            if (at_last) begin
              state  <= HALT;
              busy   <= 1'b0;
              halted <= 1'b1;
            end else begin
              state <= FETCH;
            end
          end
        end
        HALT: begin
          // Clear has priority; start is ignored here and only seen from IDLE.
          if (clear) begin
            state  <= IDLE;
            halted <= 1'b0;
          end
        end
        default: begin
          state      <= IDLE;
          busy       <= 1'b0;
          halted     <= 1'b0;
          exec_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: two instances (13- and 4-word
// programs) checked against a transaction-level model of the issue stream.
module tb_instr_fetch_unit;

  localparam logic [7:0] HALT_W = 8'h0C;

  logic       clk = 1'b0;
  logic       rst [2];
  logic       start [2];
  logic       clear [2];
  logic       exec_ready [2];
  logic [4:0] imem_addr [2];
  logic [7:0] imem_data [2];
  logic       exec_valid [2];
  logic [2:0] exec_opcode [2];
  logic [4:0] exec_addr [2];
  logic       busy [2];
  logic       halted [2];
  logic [7:0] retired_count [2];

  logic [7:0] mem0 [32];
  logic [7:0] mem1 [32];

  int checks = 0;
  int errors = 0;
  int exp_retired [2];
  int last_pc [2];
  logic [12:0] exp_q [$];

  always #5 clk = ~clk;

  assign imem_data[0] = mem0[imem_addr[0]];
  assign imem_data[1] = mem1[imem_addr[1]];

  instr_fetch_unit #(.PROG_LEN(13), .HALT_WORD(8'h0C)) dut (
    .clk (clk), .rst (rst[0]), .start (start[0]), .clear (clear[0]),
    .imem_addr (imem_addr[0]), .imem_data (imem_data[0]),
    .exec_valid (exec_valid[0]), .exec_ready (exec_ready[0]),
    .exec_opcode (exec_opcode[0]), .exec_addr (exec_addr[0]),
    .busy (busy[0]), .halted (halted[0]), .retired_count (retired_count[0])
  );

  instr_fetch_unit #(.PROG_LEN(4), .HALT_WORD(8'h0C)) dut4 (
    .clk (clk), .rst (rst[1]), .start (start[1]), .clear (clear[1]),
    .imem_addr (imem_addr[1]), .imem_data (imem_data[1]),
    .exec_valid (exec_valid[1]), .exec_ready (exec_ready[1]),
    .exec_opcode (exec_opcode[1]), .exec_addr (exec_addr[1]),
    .busy (busy[1]), .halted (halted[1]), .retired_count (retired_count[1])
  );

  task automatic check_output(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] mem_word(input int idx, input int a);
    return (idx == 0) ? mem0[a] : mem1[a];
  endfunction

  // Runs one program from IDLE; mode 0 = ready high, 1 = random ready/clear, 2 = stall on 8'h42.
  task automatic apply_stimulus(input int idx, input int mode);
    int len;
    int halt_pc;
    int cyc;
    int last_hs;
    int held;
    logic r;
    logic [7:0] w;
    logic [12:0] head;
    len = (idx == 0) ? 13 : 4;
    halt_pc = len - 1;
    exp_q.delete();
    for (int a = 0; a < len; a++) begin
      w = mem_word(idx, a);
      if (w == HALT_W) begin
        halt_pc = a;
        break;
      end
      exp_q.push_back({5'(a), w});
    end
    exp_retired[idx] = exp_retired[idx] + exp_q.size();
    if (exp_retired[idx] > 255) exp_retired[idx] = 255;
    last_pc[idx] = halt_pc;

    start[idx] = 1'b1;
    exec_ready[idx] = 1'b0;
    @(negedge clk);
    start[idx] = 1'b0;
    cyc = 0;
    last_hs = -1;
    held = 0;
    while (!halted[idx] && cyc < 400) begin
      check_output("addr_range", 32'(imem_addr[idx] <= 5'(len - 1)), 1);
      r = 1'b1;
      if (exec_valid[idx]) begin
        if (exp_q.size() == 0) begin
          check_output("extra_issue", 1, 0);
        end else begin
          head = exp_q[0];
          check_output("opcode", exec_opcode[idx], head[7:5]);
          check_output("operand", exec_addr[idx], head[4:0]);
          check_output("pc_at_issue", imem_addr[idx], head[12:8]);
          if (mode == 1) r = 1'($urandom_range(0, 1));
          if (mode == 2 && head[7:0] == 8'h42 && held < 4) begin
            r = 1'b0;
            held++;
          end
          if (r) begin
            if (mode == 0 && last_hs >= 0) check_output("issue_spacing", cyc - last_hs, 3);
            last_hs = cyc;
            void'(exp_q.pop_front());
          end
        end
      end
      exec_ready[idx] = r;
      clear[idx] = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
      @(negedge clk);
      cyc++;
    end
    clear[idx] = 1'b0;
    exec_ready[idx] = 1'b0;
    check_output("no_timeout", 32'(cyc < 400), 1);
    check_output("halted", halted[idx], 1);
    check_output("all_issued", exp_q.size(), 0);
    check_output("retired", retired_count[idx], exp_retired[idx]);
    check_output("halt_pc", imem_addr[idx], halt_pc);
    check_output("busy_in_halt", busy[idx], 0);
    check_output("valid_in_halt", exec_valid[idx], 0);
    if (mode == 2) check_output("stall_cycles", held, 4);
  endtask

  // From HALT: start alone is ignored, start+clear returns to IDLE with pc=0.
  task automatic restart(input int idx);
    start[idx] = 1'b1;
    repeat (3) @(negedge clk);
    check_output("start_ignored_halted", halted[idx], 1);
    check_output("start_ignored_pc", imem_addr[idx], last_pc[idx]);
    clear[idx] = 1'b1;
    @(negedge clk);
    start[idx] = 1'b0;
    clear[idx] = 1'b0;
    check_output("clear_halted", halted[idx], 0);
    check_output("clear_busy", busy[idx], 0);
    check_output("clear_pc", imem_addr[idx], 0);
    @(negedge clk);
    check_output("idle_after_clear", busy[idx], 0);
  endtask

  initial begin
    logic [7:0] prog [13];
    int wait_cyc;
    prog = '{8'h00, 8'h21, 8'h42, 8'h63, 8'h84, 8'hA5, 8'hC6,
             8'h07, 8'h28, 8'h49, 8'h8A, 8'hCB, 8'h0C};
    for (int i = 0; i < 2; i++) begin
      rst[i] = 1'b1;
      start[i] = 1'b0;
      clear[i] = 1'b0;
      exec_ready[i] = 1'b0;
      exp_retired[i] = 0;
      last_pc[i] = 0;
    end
    for (int a = 0; a < 32; a++) begin
      mem0[a] = 8'h00;
      mem1[a] = 8'h00;
    end
    repeat (2) @(negedge clk);
    rst[0] = 1'b0;
    rst[1] = 1'b0;
    repeat (5) @(negedge clk);
    check_output("rst_addr", imem_addr[0], 0);
    check_output("rst_valid", exec_valid[0], 0);
    check_output("rst_opcode", exec_opcode[0], 0);
    check_output("rst_operand", exec_addr[0], 0);
    check_output("rst_busy", busy[0], 0);
    check_output("rst_halted", halted[0], 0);
    check_output("rst_retired", retired_count[0], 0);
    check_output("rst_addr4", imem_addr[1], 0);

    $display("[TB] full program, ready high");
    for (int a = 0; a < 13; a++) mem0[a] = prog[a];
    apply_stimulus(0, 0);

    $display("[TB] restart and backpressure on 8'h42");
    restart(0);
    apply_stimulus(0, 2);

    $display("[TB] random programs and ready");
    for (int it = 0; it < 12; it++) begin
      restart(0);
      for (int a = 0; a < 13; a++) mem0[a] = 8'($urandom);
      if ($urandom_range(0, 1) == 1) mem0[$urandom_range(0, 12)] = HALT_W;
      apply_stimulus(0, 1);
    end

    $display("[TB] short program, end without halt word, counter saturation");
    for (int it = 0; it < 70; it++) begin
      for (int a = 0; a < 4; a++) begin
        mem1[a] = 8'($urandom);
        if (mem1[a] == HALT_W) mem1[a] = 8'h0D;
      end
      apply_stimulus(1, (it < 3) ? 0 : 1);
      restart(1);
    end
    check_output("saturated", retired_count[1], 8'hFF);

    $display("[TB] async reset mid-issue");
    restart(0);
    mem0[0] = 8'hB3;
    start[0] = 1'b1;
    exec_ready[0] = 1'b0;
    @(negedge clk);
    start[0] = 1'b0;
    wait_cyc = 0;
    while (!exec_valid[0] && wait_cyc < 20) begin
      @(negedge clk);
      wait_cyc++;
    end
    check_output("valid_before_reset", exec_valid[0], 1);
    rst[0] = 1'b1;
    #1;
    check_output("reset_drops_valid", exec_valid[0], 0);
    check_output("reset_pc", imem_addr[0], 0);
    check_output("reset_retired", retired_count[0], 0);
    check_output("reset_busy", busy[0], 0);
    @(negedge clk);
    rst[0] = 1'b0;
    exp_retired[0] = 0;
    @(negedge clk);
    for (int a = 0; a < 13; a++) mem0[a] = prog[a];
    apply_stimulus(0, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
